// File: rtl/game_timer_ctrl_if.sv
// Command/status bundle between the game logic and the round timer.
// The warn status line is present only when TIMER_WARN_EN is defined.
interface game_timer_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             start;
  logic             pause;
  logic             tick;
  logic [CNT_W-1:0] remaining;
  logic             running;
  logic             expired;
  logic [1:0]       state;
`ifdef TIMER_WARN_EN
  logic             warn;
`endif

  // Game logic side: issues commands, observes timer status.
  modport master (
    output load, load_val, start, pause,
`ifdef TIMER_WARN_EN
    input  warn,
`endif
    input  tick, remaining, running, expired, state
  );

  // Timer side: accepts commands, drives status.
  modport slave (
    input  load, load_val, start, pause,
`ifdef TIMER_WARN_EN
    output warn,
`endif
    output tick, remaining, running, expired, state
  );
endinterface

// File: rtl/game_timer_ctrl.sv
// Countdown round timer with an internal clock-enable prescaler.
// tick is an enable pulse on clk, never a derived clock.
// Optional feature macro: TIMER_WARN_EN adds the registered low-time warn flag.
module game_timer_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 8,
  parameter int WARN_TH  = 5
) (
  input logic               clk,
  input logic               reset,
  game_timer_ctrl_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic [1:0]       stateReg, stateNext;
  logic [PW-1:0]    prescReg, prescNext;
  logic [CNT_W-1:0] remReg, remNext;
  logic             tickReg, tickNext;
  logic             expReg, expNext;
  logic             runReg;

  // Next-state decode; load outranks pause, pause outranks start, and a pause
  // landing on the wrap cycle suppresses the tick while the prescaler holds.
  always_comb begin
    stateNext = stateReg;
    prescNext = prescReg;
    remNext   = remReg;
    tickNext  = 1'b0;
    expNext   = 1'b0;
    if (bus.load) begin
      remNext   = bus.load_val;
      prescNext = '0;
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.start && (remReg != '0)) begin
            stateNext = RUN;
            prescNext = '0;
          end
        end
        RUN: begin
          if (bus.pause) begin
            stateNext = PAUSE;
          end else if (prescReg == DIV_LAST) begin
            prescNext = '0;
            tickNext  = 1'b1;
            if (remReg != '0) begin
              remNext = remReg - 1'b1;
            end
            if (remReg == CNT_W'(1)) begin
              stateNext = DONE;
              expNext   = 1'b1;
            end
          end else begin
            prescNext = prescReg + 1'b1;
          end
        end
        PAUSE: begin
          if (bus.start) begin
            stateNext = RUN;
          end
        end
        default: begin
          remNext = '0;
        end
      endcase
    end
  end

  // Register all state and status so every output is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      prescReg <= '0;
      remReg   <= '0;
      tickReg  <= 1'b0;
      expReg   <= 1'b0;
      runReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      prescReg <= prescNext;
      remReg   <= remNext;
      tickReg  <= tickNext;
      expReg   <= expNext;
      runReg   <= (stateNext == RUN);
    end
  end

`ifdef TIMER_WARN_EN
  logic warnReg;

  // Warn while running with few ticks left, tracking the same cycle remaining changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      warnReg <= 1'b0;
    end else begin
      warnReg <= (stateNext == RUN) && (remNext <= CNT_W'(WARN_TH)) && (remNext != '0);
    end
  end

  assign bus.warn = warnReg;
`endif

  assign bus.state     = stateReg;
  assign bus.remaining = remReg;
  assign bus.tick      = tickReg;
  assign bus.expired   = expReg;
  assign bus.running   = runReg;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with TICK_DIV=4, CNT_W=8, WARN_TH=2.
// Warn checks are compiled in only when TIMER_WARN_EN is defined.
module tb_game_timer_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  game_timer_ctrl_if #(.CNT_W(8)) bus ();

  game_timer_ctrl #(.TICK_DIV(4), .CNT_W(8), .WARN_TH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs set before this are sampled, outputs read after it are settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    if (bus.state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state got %b want 00", bus.state); end
    checks++;
    if (bus.remaining !== 8'd0) begin errors++; $display("[TB] FAIL reset_remaining got %0d want 0", bus.remaining); end
    checks++;
    if (bus.tick !== 1'b0 || bus.expired !== 1'b0 || bus.running !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags got tick=%b exp=%b run=%b want 0 0 0", bus.tick, bus.expired, bus.running);
    end
    checks++;
`ifdef TIMER_WARN_EN
    if (bus.warn !== 1'b0) begin errors++; $display("[TB] FAIL reset_warn got %b want 0", bus.warn); end
    checks++;
`endif
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    if (bus.state !== 2'b00 || bus.running !== 1'b0) begin
      errors++; $display("[TB] FAIL start_zero_ignored got state=%b run=%b want 00 0", bus.state, bus.running);
    end
    checks++;
  endtask

  task automatic test_countdown();
    bus.load_val = 8'd3;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    if (bus.remaining !== 8'd3 || bus.state !== 2'b00) begin
      errors++; $display("[TB] FAIL load3 got rem=%0d state=%b want 3 00", bus.remaining, bus.state);
    end
    checks++;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    if (bus.state !== 2'b01 || bus.running !== 1'b1) begin
      errors++; $display("[TB] FAIL start_run got state=%b run=%b want 01 1", bus.state, bus.running);
    end
    checks++;
    for (int k = 1; k <= 12; k++) begin
      logic       expTick;
      logic       expExp;
      logic [7:0] expRem;
      cyc();
      expTick = (k % 4 == 0);
      expExp  = (k == 12);
      expRem  = 8'(3 - k / 4);
      if (bus.tick !== expTick || bus.expired !== expExp || bus.remaining !== expRem) begin
        errors++;
        $display("[TB] FAIL countdown_c%0d got tick=%b exp=%b rem=%0d want %b %b %0d",
                 k, bus.tick, bus.expired, bus.remaining, expTick, expExp, expRem);
      end
      checks++;
    end
    if (bus.state !== 2'b11 || bus.running !== 1'b0) begin
      errors++; $display("[TB] FAIL done_state got state=%b run=%b want 11 0", bus.state, bus.running);
    end
    checks++;
    cyc();
    if (bus.expired !== 1'b0 || bus.tick !== 1'b0 || bus.state !== 2'b11) begin
      errors++; $display("[TB] FAIL done_quiet got exp=%b tick=%b state=%b want 0 0 11", bus.expired, bus.tick, bus.state);
    end
    checks++;
  endtask

  task automatic test_pause_resume();
    int sawTick;
    bus.load_val = 8'd5;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (6) cyc();
    if (bus.remaining !== 8'd4) begin errors++; $display("[TB] FAIL pre_pause_rem got %0d want 4", bus.remaining); end
    checks++;
    bus.pause = 1'b1;
    cyc();
    bus.pause = 1'b0;
    if (bus.state !== 2'b10 || bus.running !== 1'b0) begin
      errors++; $display("[TB] FAIL pause_state got state=%b run=%b want 10 0", bus.state, bus.running);
    end
    checks++;
    sawTick = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (bus.tick === 1'b1) sawTick++;
    end
    if (sawTick !== 0 || bus.remaining !== 8'd4) begin
      errors++; $display("[TB] FAIL pause_hold got ticks=%0d rem=%0d want 0 4", sawTick, bus.remaining);
    end
    checks++;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    if (bus.state !== 2'b01 || bus.tick !== 1'b0) begin
      errors++; $display("[TB] FAIL resume got state=%b tick=%b want 01 0", bus.state, bus.tick);
    end
    checks++;
    cyc();
    if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL resume_c1 got tick=%b want 0", bus.tick); end
    checks++;
    cyc();
    if (bus.tick !== 1'b1 || bus.remaining !== 8'd3) begin
      errors++; $display("[TB] FAIL resume_c2 got tick=%b rem=%0d want 1 3", bus.tick, bus.remaining);
    end
    checks++;
  endtask

  task automatic test_done_hold();
    bus.load_val = 8'd1;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (4) cyc();
    if (bus.state !== 2'b11 || bus.expired !== 1'b1 || bus.remaining !== 8'd0) begin
      errors++; $display("[TB] FAIL one_tick_done got state=%b exp=%b rem=%0d want 11 1 0", bus.state, bus.expired, bus.remaining);
    end
    checks++;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.pause = 1'b1;
    cyc();
    bus.pause = 1'b0;
    if (bus.state !== 2'b11 || bus.remaining !== 8'd0 || bus.running !== 1'b0) begin
      errors++; $display("[TB] FAIL done_ignores got state=%b rem=%0d run=%b want 11 0 0", bus.state, bus.remaining, bus.running);
    end
    checks++;
    bus.load_val = 8'd2;
    bus.load = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b0;
    if (bus.state !== 2'b00 || bus.remaining !== 8'd2) begin
      errors++; $display("[TB] FAIL load_over_start got state=%b rem=%0d want 00 2", bus.state, bus.remaining);
    end
    checks++;
  endtask

  task automatic test_pause_on_wrap();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (3) cyc();
    bus.pause = 1'b1;
    cyc();
    bus.pause = 1'b0;
    if (bus.tick !== 1'b0 || bus.state !== 2'b10 || bus.remaining !== 8'd2) begin
      errors++; $display("[TB] FAIL pause_wrap got tick=%b state=%b rem=%0d want 0 10 2", bus.tick, bus.state, bus.remaining);
    end
    checks++;
    repeat (3) cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL wrap_resume got tick=%b want 0", bus.tick); end
    checks++;
    cyc();
    if (bus.tick !== 1'b1 || bus.remaining !== 8'd1) begin
      errors++; $display("[TB] FAIL wrap_tick got tick=%b rem=%0d want 1 1", bus.tick, bus.remaining);
    end
    checks++;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    if (bus.state !== 2'b00 || bus.remaining !== 8'd0 || bus.tick !== 1'b0 ||
        bus.expired !== 1'b0 || bus.running !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_reset got state=%b rem=%0d tick=%b exp=%b run=%b want 00 0 0 0 0",
                         bus.state, bus.remaining, bus.tick, bus.expired, bus.running);
    end
    checks++;
  endtask

`ifdef TIMER_WARN_EN
  task automatic test_warn();
    bus.load_val = 8'd4;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    if (bus.warn !== 1'b0) begin errors++; $display("[TB] FAIL warn_start got %b want 0", bus.warn); end
    checks++;
    for (int k = 1; k <= 16; k++) begin
      logic expWarn;
      cyc();
      expWarn = (k >= 8 && k < 16);
      if (bus.warn !== expWarn) begin
        errors++; $display("[TB] FAIL warn_c%0d got %b want %b (rem=%0d)", k, bus.warn, expWarn, bus.remaining);
      end
      checks++;
    end
    if (bus.state !== 2'b11) begin errors++; $display("[TB] FAIL warn_done got state=%b want 11", bus.state); end
    checks++;
  endtask
`endif

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 8'd0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    test_reset();
    test_countdown();
    test_pause_resume();
    test_done_hold();
    test_pause_on_wrap();
`ifdef TIMER_WARN_EN
    test_warn();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
